// File: rtl/dac_cmd_ctrl_pkg.sv
// Shared definitions for the LTC2624 command sequencer: state encoding,
// DAC command/address constants and the 32-bit word packer.
package dac_cmd_pkg;

    localparam logic [2:0] ST_CLEAR     = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_LOAD      = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    localparam logic [3:0] CMD_WRITE        = 4'h0;
    localparam logic [3:0] CMD_UPDATE       = 4'h1;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
    localparam logic [3:0] CMD_POWER_DOWN   = 4'h4;
    localparam logic [3:0] CMD_NOP          = 4'hF;

    localparam logic [3:0] ADDR_ALL = 4'hF;

    // LTC2624 32-bit frame: 8 don't-care bits, command, address, 12-bit code, 4 pad bits.
    function automatic logic [31:0] pack_word(input logic [3:0] cmd,
                                              input logic [3:0] addr,
                                              input logic [11:0] data);
        return {8'h00, cmd, addr, data, 4'h0};
    endfunction

endpackage

// File: rtl/dac_cmd_ctrl.sv
// LTC2624 command sequencer feeding a 32-bit SPI shifter.
// Optional SDO echo check enabled by defining DAC_CMD_CTRL_ECHO_CHECK_EN.
//
// Request handshake: a command transfers on a rising edge where req_valid and
// req_ready are both high; req_ready depends only on state (high in IDLE), and
// request fields are sampled on that edge only.
module dac_cmd_ctrl #(
    parameter int CLR_CYCLES     = 50,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [3:0]  req_addr,
    input  logic [11:0] req_data,
    output logic [31:0] spi_data_in,
    output logic        spi_trig,
    input  logic        spi_done,
    input  logic [31:0] spi_data_out,
    output logic        dac_clr,
    output logic        busy,
    output logic        timeout_err,
    output logic        echo_err,
    output logic [2:0]  state_dbg
);
    import dac_cmd_pkg::*;

    localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    // With no guard gap the transfer returns straight to IDLE.
    localparam logic [2:0] ST_AFTER_XFER = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    logic [2:0]  state;
    logic [15:0] counter;
    logic        wait_expired;

    assign req_ready    = (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign spi_trig     = (state == ST_LOAD);
    assign state_dbg    = state;
    assign wait_expired = (state == ST_WAIT_DONE) && !spi_done && (counter == TO_LAST);

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state       <= ST_CLEAR;
            counter     <= 16'd0;
            dac_clr     <= 1'b0;
            spi_data_in <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (counter == CLR_LAST) begin
                        dac_clr <= 1'b1;
                        state   <= ST_IDLE;
                        counter <= 16'd0;
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        spi_data_in <= pack_word(req_cmd, req_addr, req_data);
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state   <= ST_WAIT_DONE;
                    counter <= 16'd0;
                end
                ST_WAIT_DONE: begin
                    // done on the limit cycle takes priority over the timeout
                    if (spi_done) begin
                        state   <= ST_AFTER_XFER;
                        counter <= 16'd0;
                    end else if (counter == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_AFTER_XFER;
                        counter     <= 16'd0;
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (counter == GAP_LAST) begin
                        state   <= ST_IDLE;
                        counter <= 16'd0;
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    counter <= 16'd0;
                end
            endcase
        end
    end

`ifdef DAC_CMD_CTRL_ECHO_CHECK_EN
    // The DAC shifts out the previous frame while the new one shifts in.
    logic [31:0] last_word;
    logic        last_valid;
    logic        echo_err_q;

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            last_word  <= 32'd0;
            last_valid <= 1'b0;
            echo_err_q <= 1'b0;
        end else if (state == ST_WAIT_DONE) begin
            if (spi_done) begin
                if (last_valid && (spi_data_out != last_word)) begin
                    echo_err_q <= 1'b1;
                end
                last_word  <= spi_data_in;
                last_valid <= 1'b1;
            end else if (wait_expired) begin
                last_valid <= 1'b0;
            end
        end
    end

    assign echo_err = echo_err_q;
`else
    logic unused_echo;
    assign unused_echo = ^{spi_data_out, wait_expired};
    assign echo_err    = 1'b0;
`endif

endmodule

// File: tb/tb_dac_cmd_ctrl.sv
// Self-checking bench for dac_cmd_ctrl: expected frames are queued on accept
// and checked when spi_trig fires; timing and sticky flags are checked inline.
module tb_dac_cmd_ctrl;
    import dac_cmd_pkg::*;

    localparam int CLR_CYCLES     = 50;
    localparam int GAP_CYCLES     = 4;
    localparam int TIMEOUT_CYCLES = 4096;

    logic        CLK50MHZ = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_cmd = 4'h0;
    logic [3:0]  req_addr = 4'h0;
    logic [11:0] req_data = 12'h000;
    logic [31:0] spi_data_in;
    logic        spi_trig;
    logic        spi_done = 1'b0;
    logic [31:0] spi_data_out = 32'd0;
    logic        dac_clr;
    logic        busy;
    logic        timeout_err;
    logic        echo_err;
    logic [2:0]  state_dbg;

    int compared   = 0;
    int mismatched = 0;
    int trig_count = 0;

    logic [31:0] exp_q[$];
    logic [31:0] cur_word    = 32'd0;
    logic [31:0] model_last  = 32'd0;
    logic        model_valid = 1'b0;
    logic        prev_trig   = 1'b0;

    dac_cmd_ctrl #(
        .CLR_CYCLES(CLR_CYCLES),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK50MHZ(CLK50MHZ),
        .RST(RST),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_cmd(req_cmd),
        .req_addr(req_addr),
        .req_data(req_data),
        .spi_data_in(spi_data_in),
        .spi_trig(spi_trig),
        .spi_done(spi_done),
        .spi_data_out(spi_data_out),
        .dac_clr(dac_clr),
        .busy(busy),
        .timeout_err(timeout_err),
        .echo_err(echo_err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #10 CLK50MHZ = ~CLK50MHZ;

    // ---------------- scoreboard: frame check on every trigger ----------------
    always @(negedge CLK50MHZ) begin
        if (spi_trig) begin
            trig_count++;
            compared++;
            if (prev_trig) begin
                mismatched++;
                $display("FAIL trig_width: spi_trig high 2 cycles, required 1");
            end
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL trig_unexpected: spi_data_in=%h with empty queue", spi_data_in);
            end else begin
                cur_word = exp_q.pop_front();
                if (spi_data_in !== cur_word) begin
                    mismatched++;
                    $display("FAIL frame: spi_data_in=%h required %h", spi_data_in, cur_word);
                end
            end
        end
        prev_trig = spi_trig;
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        RST       = 1'b1;
        req_valid = 1'b0;
        spi_done  = 1'b0;
        repeat (3) @(posedge CLK50MHZ);
        #1;
        exp_q.delete();
        model_valid = 1'b0;
    endtask

    task automatic count_clr_low(output int n);
        n = 0;
        @(negedge CLK50MHZ);
        while (!dac_clr && n < 500) begin
            n++;
            compared++;
            if (req_ready !== 1'b0 || spi_trig !== 1'b0) begin
                mismatched++;
                $display("FAIL clear_quiet: req_ready=%b spi_trig=%b required 0/0", req_ready, spi_trig);
            end
            @(negedge CLK50MHZ);
        end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_with_clr: req_ready=%b required 1 when dac_clr rises", req_ready);
        end
    endtask

    task automatic send_req(input logic [3:0] cmd, input logic [3:0] addr, input logic [11:0] data);
        int n;
        @(negedge CLK50MHZ);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_data  = data;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge CLK50MHZ);
            n++;
        end
        compared++;
        if (!req_ready) begin
            mismatched++;
            $display("FAIL accept_wait: req_ready=%b required 1 within 200 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back({8'h00, cmd, addr, data, 4'h0});
        @(posedge CLK50MHZ);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_trig(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge CLK50MHZ);
            n++;
        end while (!spi_trig && n < budget);
        compared++;
        if (!spi_trig) begin
            mismatched++;
            $display("FAIL trig_wait: spi_trig=0 required 1 within %0d cycles", budget);
        end
    endtask

    // Called on the trigger cycle; done is sampled `delay` edges later.
    task automatic respond(input int delay, input logic [31:0] flip);
        repeat (delay - 1) @(negedge CLK50MHZ);
        spi_done     = 1'b1;
        spi_data_out = (model_valid ? model_last : $urandom()) ^ flip;
        @(negedge CLK50MHZ);
        spi_done    = 1'b0;
        model_last  = cur_word;
        model_valid = 1'b1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge CLK50MHZ);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        apply_reset();
        compared++;
        if (dac_clr !== 1'b0 || spi_trig !== 1'b0 || spi_data_in !== 32'd0 ||
            req_ready !== 1'b0 || busy !== 1'b1 || state_dbg !== ST_CLEAR) begin
            mismatched++;
            $display("FAIL reset_outputs: clr=%b trig=%b data=%h ready=%b busy=%b state=%0d required 0/0/0/0/1/%0d",
                     dac_clr, spi_trig, spi_data_in, req_ready, busy, state_dbg, ST_CLEAR);
        end
        compared++;
        if (timeout_err !== 1'b0 || echo_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_flags: timeout_err=%b echo_err=%b required 0/0", timeout_err, echo_err);
        end
        RST = 1'b0;
        count_clr_low(n);
        compared++;
        if (n != CLR_CYCLES) begin
            mismatched++;
            $display("FAIL clr_length: dac_clr low %0d cycles required %0d", n, CLR_CYCLES);
        end
    endtask

    task automatic test_write_update();
        int n;
        send_req(CMD_WRITE_UPDATE, 4'h0, 12'hABC);
        @(negedge CLK50MHZ);
        compared++;
        if (spi_trig !== 1'b1 || spi_data_in !== 32'h0030ABC0) begin
            mismatched++;
            $display("FAIL write_update: trig=%b data=%h required 1/0030abc0", spi_trig, spi_data_in);
        end
        respond(70, 32'd0);
        count_busy(n);
        compared++;
        if (n != GAP_CYCLES) begin
            mismatched++;
            $display("FAIL gap_busy: busy for %0d cycles after done required %0d", n, GAP_CYCLES);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int n;
        logic [11:0] d2;
        d2    = 12'($urandom_range(0, 4095));
        start = trig_count;
        @(negedge CLK50MHZ);
        req_valid = 1'b1;
        req_cmd   = CMD_WRITE;
        req_addr  = 4'h2;
        req_data  = 12'h5A5;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge CLK50MHZ);
            n++;
        end
        exp_q.push_back({8'h00, CMD_WRITE, 4'h2, 12'h5A5, 4'h0});
        @(posedge CLK50MHZ);
        #1;
        req_cmd  = CMD_UPDATE;
        req_addr = ADDR_ALL;
        req_data = d2;
        exp_q.push_back({8'h00, CMD_UPDATE, ADDR_ALL, d2, 4'h0});
        wait_trig(10);
        respond(10, 32'd0);
        n = 1;
        while (!spi_trig && n < 50) begin
            @(negedge CLK50MHZ);
            n++;
        end
        req_valid = 1'b0;
        compared++;
        if (n != GAP_CYCLES + 2) begin
            mismatched++;
            $display("FAIL b2b_latency: second trig %0d cycles after done required %0d", n, GAP_CYCLES + 2);
        end
        respond(6, 32'd0);
        repeat (10) @(negedge CLK50MHZ);
        compared++;
        if (trig_count - start != 2) begin
            mismatched++;
            $display("FAIL b2b_count: %0d triggers required 2", trig_count - start);
        end
    endtask

    task automatic test_stray();
        int start;
        start = trig_count;
        @(negedge CLK50MHZ);
        spi_done = 1'b1;
        @(negedge CLK50MHZ);
        spi_done = 1'b0;
        @(negedge CLK50MHZ);
        compared++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || state_dbg !== ST_IDLE || trig_count != start) begin
            mismatched++;
            $display("FAIL stray_done: busy=%b ready=%b state=%0d trigs=%0d required 0/1/%0d/0",
                     busy, req_ready, state_dbg, trig_count - start, ST_IDLE);
        end
    endtask

    task automatic test_timeout();
        int n;
        send_req(CMD_POWER_DOWN, 4'h1, 12'h000);
        wait_trig(10);
        n = 0;
        while (!timeout_err && n < 5000) begin
            @(negedge CLK50MHZ);
            n++;
            if (!timeout_err) begin
                compared++;
                if (busy !== 1'b1) begin
                    mismatched++;
                    $display("FAIL timeout_busy: busy=%b required 1 while waiting", busy);
                end
            end
        end
        compared++;
        if (n != TIMEOUT_CYCLES + 1) begin
            mismatched++;
            $display("FAIL timeout_time: timeout_err after %0d cycles required %0d", n, TIMEOUT_CYCLES + 1);
        end
        model_valid = 1'b0;
        count_busy(n);
        compared++;
        if (n != GAP_CYCLES) begin
            mismatched++;
            $display("FAIL timeout_gap: busy %0d cycles after timeout required %0d", n, GAP_CYCLES);
        end
        send_req(CMD_WRITE, 4'h3, 12'h123);
        wait_trig(10);
        respond(5, 32'd0);
        compared++;
        if (timeout_err !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_sticky: timeout_err=%b required 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        send_req(CMD_WRITE_UPDATE, 4'h1, 12'hFFF);
        wait_trig(10);
        repeat (10) @(negedge CLK50MHZ);
        RST = 1'b1;
        @(posedge CLK50MHZ);
        #1;
        compared++;
        if (dac_clr !== 1'b0 || busy !== 1'b1 || spi_trig !== 1'b0 || spi_data_in !== 32'd0 ||
            timeout_err !== 1'b0 || state_dbg !== ST_CLEAR) begin
            mismatched++;
            $display("FAIL mid_reset: clr=%b busy=%b trig=%b data=%h terr=%b state=%0d required 0/1/0/0/0/%0d",
                     dac_clr, busy, spi_trig, spi_data_in, timeout_err, state_dbg, ST_CLEAR);
        end
        RST = 1'b0;
        exp_q.delete();
        model_valid = 1'b0;
        count_clr_low(n);
        compared++;
        if (n != CLR_CYCLES) begin
            mismatched++;
            $display("FAIL mid_clr_length: dac_clr low %0d cycles required %0d", n, CLR_CYCLES);
        end
    endtask

`ifdef DAC_CMD_CTRL_ECHO_CHECK_EN
    task automatic test_echo();
        send_req(CMD_WRITE, 4'h0, 12'h111);
        wait_trig(10);
        respond(4, 32'd0);
        send_req(CMD_WRITE, 4'h1, 12'h222);
        wait_trig(10);
        respond(4, 32'd0);
        compared++;
        if (echo_err !== 1'b0) begin
            mismatched++;
            $display("FAIL echo_good: echo_err=%b required 0", echo_err);
        end
        send_req(CMD_WRITE, 4'h2, 12'h333);
        wait_trig(10);
        respond(4, 32'h0000_0400);
        compared++;
        if (echo_err !== 1'b1) begin
            mismatched++;
            $display("FAIL echo_bad: echo_err=%b required 1", echo_err);
        end
        send_req(CMD_UPDATE, ADDR_ALL, 12'h444);
        wait_trig(10);
        respond(4, 32'd0);
        compared++;
        if (echo_err !== 1'b1) begin
            mismatched++;
            $display("FAIL echo_sticky: echo_err=%b required 1", echo_err);
        end
    endtask
`else
    task automatic test_echo();
        send_req(CMD_WRITE, 4'h0, 12'h111);
        wait_trig(10);
        respond(4, 32'hFFFF_FFFF);
        compared++;
        if (echo_err !== 1'b0) begin
            mismatched++;
            $display("FAIL echo_tied: echo_err=%b required 0", echo_err);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_update();
        test_back_to_back();
        test_stray();
        test_timeout();
        test_reset_mid();
        test_echo();
        repeat (5) @(negedge CLK50MHZ);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drain: %0d frames never triggered required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
